// File: rtl/b10_stim_sequencer.sv
// Opcode player feeding the b10 voting core; optional response MISR
// compiled in with SIG_MISR_EN, otherwise signature is tied to zero.
module b10_stim_sequencer #(
    parameter int DEPTH = 11,
    parameter int AW    = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [11:0]   load_data,
    input  logic          run,
    input  logic          stop,
    input  logic          loop_en,
    input  logic [AW-1:0] length,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] pc,
    output logic          r_button,
    output logic          g_button,
    output logic          key,
    output logic          start,
    output logic          test,
    output logic          rts,
    output logic          rtr,
    output logic          obs,
    output logic [3:0]    v_in,
    input  logic [3:0]    v_out_in,
    input  logic          cts_in,
    input  logic          ctr_in,
    output logic [15:0]   signature
);

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic          start_q, start_d;
    logic [AW-1:0] len_q, len_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [11:0]   op_q, op_d;
    logic [11:0]   mem_q [DEPTH];
    logic [AW-1:0] len_clip;
    logic [AW-1:0] pc_inc;
    logic          wr_en;
    logic          sig_clr;
    logic          sig_upd;

    // start_q marks the fetch cycle between the accepting edge and entry 0
    always_comb begin
        state_d  = state_q;
        start_d  = start_q;
        len_d    = len_q;
        pc_d     = pc_q;
        op_d     = op_q;
        wr_en    = 1'b0;
        sig_clr  = 1'b0;
        sig_upd  = 1'b0;
        pc_inc   = pc_q + AW'(1);
        len_clip = (length > AW'(DEPTH)) ? AW'(DEPTH) : length;
        unique case (state_q)
            IDLE: begin
                op_d = '0;
                pc_d = '0;
                if (start_q) begin
                    start_d = 1'b0;
                    if (len_q == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = PLAY;
                        op_d    = mem_q[0];
                    end
                end else if (run) begin
                    start_d = 1'b1;
                    len_d   = len_clip;
                    sig_clr = 1'b1;
                end else if (load_en && (load_addr < AW'(DEPTH))) begin
                    wr_en = 1'b1;
                end
            end
            PLAY: begin
                if (stop) begin
                    state_d = IDLE;
                    op_d    = '0;
                    pc_d    = '0;
                end else begin
                    sig_upd = 1'b1;
                    if (pc_q < len_q - AW'(1)) begin
                        pc_d = pc_inc;
                        op_d = mem_q[pc_inc];
                    end else if (loop_en) begin
                        pc_d = '0;
                        op_d = mem_q[0];
                    end else begin
                        state_d = DONE;
                        pc_d    = '0;
                        op_d    = '0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                pc_d    = '0;
                op_d    = '0;
            end
            default: begin
                state_d = IDLE;
                start_d = 1'b0;
                pc_d    = '0;
                op_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            len_q   <= '0;
            pc_q    <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            len_q   <= len_d;
            pc_q    <= pc_d;
            op_q    <= op_d;
        end
    end

    // Opcode store deliberately survives reset
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[load_addr] <= load_data;
        end
    end

    assign busy     = (state_q == PLAY);
    assign done     = (state_q == DONE);
    assign pc       = pc_q;
    assign r_button = op_q[0];
    assign g_button = op_q[1];
    assign key      = op_q[2];
    assign start    = op_q[3];
    assign test     = op_q[4];
    assign rts      = op_q[5];
    assign rtr      = op_q[6];
    assign v_in     = op_q[10:7];
    assign obs      = op_q[11];

`ifdef SIG_MISR_EN
    logic [15:0] sig_q, sig_d;

    always_comb begin
        sig_d = sig_q;
        if (sig_clr) begin
            sig_d = '0;
        end else if (sig_upd) begin
            sig_d = {sig_q[14:0], 1'b0}
                  ^ (sig_q[15] ? 16'h1021 : 16'h0000)
                  ^ {10'b0, ctr_in, cts_in, v_out_in};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign signature = sig_q;
`else
    logic unused_resp;
    assign unused_resp = ^{sig_clr, sig_upd, v_out_in, cts_in, ctr_in};
    assign signature   = 16'h0000;
`endif

endmodule

// File: tb/tb_b10_stim_sequencer.sv
// Random + directed bench for b10_stim_sequencer against a cycle-level
// reference model of the player schedule and response signature.
module tb_b10_stim_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        load_en;
    logic [3:0]  load_addr;
    logic [11:0] load_data;
    logic        run;
    logic        stop;
    logic        loop_en;
    logic [3:0]  length;
    logic        busy;
    logic        done;
    logic [3:0]  pc;
    logic        r_button, g_button, key, start, test, rts, rtr, obs;
    logic [3:0]  v_in;
    logic [3:0]  v_out_in;
    logic        cts_in;
    logic        ctr_in;
    logic [15:0] signature;

    b10_stim_sequencer dut (
        .clock     (clock),
        .reset     (reset),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .run       (run),
        .stop      (stop),
        .loop_en   (loop_en),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .pc        (pc),
        .r_button  (r_button),
        .g_button  (g_button),
        .key       (key),
        .start     (start),
        .test      (test),
        .rts       (rts),
        .rtr       (rtr),
        .obs       (obs),
        .v_in      (v_in),
        .v_out_in  (v_out_in),
        .cts_in    (cts_in),
        .ctr_in    (ctr_in),
        .signature (signature)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // reference model: phase 0 idle, 1 playing, 2 done pulse
    int          m_phase;
    bit          m_pend;
    int          m_len;
    int          m_pc;
    int          m_sig;
    logic [11:0] m_mem [11];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic int misr_next(int s, int r);
        int v;
        v = (s * 2) % 65536;
        if (s >= 32768) v = v ^ 'h1021;
        return v ^ r;
    endfunction

    function automatic logic [11:0] stim_now();
        return {obs, v_in, rtr, rts, test, start, key, g_button, r_button};
    endfunction

    task automatic model_edge();
        if (reset) begin
            m_phase = 0;
            m_pend  = 0;
            m_len   = 0;
            m_pc    = 0;
            m_sig   = 0;
        end else if (m_phase == 0) begin
            if (m_pend) begin
                m_pend  = 0;
                m_pc    = 0;
                m_phase = (m_len == 0) ? 2 : 1;
            end else if (run) begin
                m_pend = 1;
                m_len  = (int'(length) > 11) ? 11 : int'(length);
                m_sig  = 0;
            end else if (load_en && load_addr < 11) begin
                m_mem[load_addr] = load_data;
            end
        end else if (m_phase == 1) begin
            if (stop) begin
                m_phase = 0;
            end else begin
                m_sig = misr_next(m_sig, {ctr_in, cts_in, v_out_in});
                if (m_pc + 1 < m_len) m_pc++;
                else if (loop_en) m_pc = 0;
                else m_phase = 2;
            end
        end else begin
            m_phase = 0;
        end
    endtask

    task automatic tick();
        int exp_sig;
        @(posedge clock);
        model_edge();
        @(negedge clock);
`ifdef SIG_MISR_EN
        exp_sig = m_sig;
`else
        exp_sig = 0;
`endif
        chk("busy", 32'(busy), 32'(m_phase == 1));
        chk("done", 32'(done), 32'(m_phase == 2));
        chk("pc", 32'(pc), (m_phase == 1) ? m_pc : 0);
        chk("stim", 32'(stim_now()),
            (m_phase == 1) ? 32'(m_mem[m_pc]) : 32'h0);
        chk("sig", 32'(signature), exp_sig);
    endtask

    task automatic idle_inputs();
        reset   = 1'b0;
        load_en = 1'b0;
        run     = 1'b0;
        stop    = 1'b0;
    endtask

    task automatic load(input int a, input logic [11:0] d);
        load_en   = 1'b1;
        load_addr = 4'(a);
        load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic kick(input int len);
        length = 4'(len);
        run    = 1'b1;
        tick();
        run = 1'b0;
        tick();
    endtask

    int busy_cnt;
    logic [11:0] golden [3];

    initial begin
        golden[0] = 12'h801;
        golden[1] = 12'h07A;
        golden[2] = 12'h400;
        idle_inputs();
        reset     = 1'b1;
        loop_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        length    = '0;
        v_out_in  = '0;
        cts_in    = 1'b0;
        ctr_in    = 1'b0;
        m_phase = 0; m_pend = 0; m_len = 0; m_pc = 0; m_sig = 0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pc", 32'(pc), 0);
        chk("rst_stim", 32'(stim_now()), 0);
        reset = 1'b0;

        for (int i = 0; i < 11; i++)
            load(i, (i < 3) ? golden[i] : 12'($urandom));
        load(13, 12'hABC);

        // basic three-entry playback
        busy_cnt = 0;
        kick(3);
        for (int k = 0; k < 3; k++) begin
            chk("t1_stim", 32'(stim_now()), 32'(golden[k]));
            chk("t1_pc", 32'(pc), k);
            busy_cnt += int'(busy);
            tick();
        end
        chk("t1_done", 32'(done), 1);
        chk("t1_busy_cnt", busy_cnt, 3);
        tick();

        // zero length goes straight to a done pulse
        length = 4'd0;
        run    = 1'b1;
        tick();
        run = 1'b0;
        chk("t2_busy", 32'(busy), 0);
        tick();
        chk("t2_done", 32'(done), 1);
        chk("t2_stim", 32'(stim_now()), 0);
        tick();
        chk("t2_done_end", 32'(done), 0);

        // looping over two entries
        loop_en = 1'b1;
        kick(2);
        for (int k = 0; k < 6; k++) begin
            chk("t3_pc", 32'(pc), k % 2);
            if (k == 4) loop_en = 1'b0;
            tick();
        end
        chk("t3_done", 32'(done), 1);
        tick();

        // stop mid-run, with a load attempt while playing
        kick(3);
        load(0, 12'hFFF);
        chk("t4_pc1", 32'(pc), 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t4_busy", 32'(busy), 0);
        chk("t4_stim", 32'(stim_now()), 0);
        chk("t4_done", 32'(done), 0);
        tick();
        kick(3);
        chk("t4_replay", 32'(stim_now()), 32'h801);
        tick();
        tick();

        // reset at pc=2 keeps memory
        chk("t5_pc2", 32'(pc), 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_pc", 32'(pc), 0);
        chk("t5_stim", 32'(stim_now()), 0);
        kick(3);
        for (int k = 0; k < 3; k++) begin
            chk("t5_replay", 32'(stim_now()), 32'(golden[k]));
            tick();
        end
        tick();

        // single-entry signature
        v_out_in = 4'hF;
        cts_in   = 1'b1;
        ctr_in   = 1'b0;
        kick(1);
        tick();
`ifdef SIG_MISR_EN
        chk("t6_sig", 32'(signature), 32'h001F);
`else
        chk("t6_sig", 32'(signature), 32'h0000);
`endif
        tick();

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            reset     = ($urandom_range(0, 299) == 0);
            load_en   = ($urandom_range(0, 2) == 0);
            load_addr = 4'($urandom_range(0, 15));
            load_data = 12'($urandom);
            run       = ($urandom_range(0, 7) == 0);
            stop      = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 9) == 0) loop_en = ~loop_en;
            length    = 4'($urandom_range(0, 15));
            v_out_in  = 4'($urandom);
            cts_in    = 1'($urandom);
            ctr_in    = 1'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
